// File: rtl/rf_writeback_pkg.sv
// Shared CPU constants for the register-file writeback slice.
package rf_writeback_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    // Width of one queued load entry: destination index plus result data.
    localparam int LQ_ENTRY_W = REG_IDX_W + DATA_W;

endpackage

// File: rtl/rf_writeback_if.sv
// Writeback bus: ALU result, load handshake, issue notification, RF write port and scoreboard.
interface rf_writeback_if;
    import rf_writeback_pkg::*;

    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [DATA_W-1:0]    alu_data;

    logic                 ld_valid;
    logic                 ld_ready;
    logic [REG_IDX_W-1:0] ld_rd;
    logic [DATA_W-1:0]    ld_data;

    logic                 issue_valid;
    logic [REG_IDX_W-1:0] issue_rd;

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_wr;
    logic [DATA_W-1:0]    rf_wd;

    logic [NUM_REGS-1:0]  busy;

    // Pipeline side that produces results and consumes the RF write port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd,
        input  ld_ready,
        input  rf_we, rf_wr, rf_wd,
        input  busy
    );

    // Writeback unit side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd,
        output ld_ready,
        output rf_we, rf_wr, rf_wd,
        output busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO holding load results until the RF write port is free.
// Push uses a valid/ready handshake; pop is a strobe ignored when empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Ready comes straight from the registered count, so a full queue never
    // accepts even when it is being drained in the same cycle.
    assign push_ready = (count != FULL_COUNT);
    assign empty      = (count == '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign head_data  = mem[rd_ptr];

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping with explicit wrap at DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback: ALU results win the single write port, load results
// wait in a queue, and a scoreboard tracks registers with writes in flight.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    rf_writeback_if.slave  wb
);

    logic                  alu_write;
    logic                  fifo_push_valid;
    logic                  fifo_push_ready;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [LQ_ENTRY_W-1:0] fifo_head;
    logic [REG_IDX_W-1:0]  head_rd;
    logic [DATA_W-1:0]     head_data;

    logic                  rf_we_q;
    logic [REG_IDX_W-1:0]  rf_wr_q;
    logic [DATA_W-1:0]     rf_wd_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;

    // Writes to x0 are discarded: ALU ones never claim the port and loads are
    // acknowledged but never queued.
    assign alu_write       = wb.alu_valid && (wb.alu_rd != '0);
    assign fifo_push_valid = wb.ld_valid && (wb.ld_rd != '0);
    assign wb.ld_ready     = fifo_push_ready;

    // The queue head only gets the port in cycles the ALU leaves it idle.
    assign fifo_pop        = !alu_write && !fifo_empty;
    assign head_rd         = fifo_head[LQ_ENTRY_W-1:DATA_W];
    assign head_data       = fifo_head[DATA_W-1:0];

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH (LQ_ENTRY_W)
    ) u_load_queue (
        .clk        (clk),
        .rst        (rst),
        .push_valid (fifo_push_valid),
        .push_ready (fifo_push_ready),
        .push_data  ({wb.ld_rd, wb.ld_data}),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .empty      (fifo_empty)
    );

    // Registered RF write port; address/data hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_wr_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= alu_write || fifo_pop;
            if (alu_write) begin
                rf_wr_q <= wb.alu_rd;
                rf_wd_q <= wb.alu_data;
            end else if (fifo_pop) begin
                rf_wr_q <= head_rd;
                rf_wd_q <= head_data;
            end
        end
    end

    // Scoreboard update: a completed write clears its bit, a new issue sets it
    // (set applied last so it wins), and x0 is never busy.
    always_comb begin
        busy_next = busy_q;
        if (rf_we_q) begin
            busy_next[rf_wr_q] = 1'b0;
        end
        if (wb.issue_valid) begin
            busy_next[wb.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign wb.rf_we = rf_we_q;
    assign wb.rf_wr = rf_wr_q;
    assign wb.rf_wd = rf_wd_q;
    assign wb.busy  = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed testbench for rf_writeback with LQ_DEPTH = 4.
module tb_rf_writeback;
    import rf_writeback_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_writeback_if wb ();

    rf_writeback #(
        .LQ_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.ld_valid    = 1'b0;
        wb.ld_rd       = '0;
        wb.ld_data     = '0;
        wb.issue_valid = 1'b0;
        wb.issue_rd    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %0b expected 0", wb.rf_we); end
        checks++; if (wb.rf_wr !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr: got %0d expected 0", wb.rf_wr); end
        checks++; if (wb.rf_wd !== 32'h0) begin errors++; $display("[TB] FAIL reset_wd: got %h expected 0", wb.rf_wd); end
        checks++; if (wb.busy !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", wb.busy); end
        checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", wb.ld_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL idle_we: got %0b expected 0", wb.rf_we); end
    endtask

    task automatic test_alu_write();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd5;
        wb.alu_data  = 32'h0000_1234;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL alu_we: got %0b expected 1", wb.rf_we); end
        checks++; if (wb.rf_wr !== 5'd5) begin errors++; $display("[TB] FAIL alu_wr: got %0d expected 5", wb.rf_wr); end
        checks++; if (wb.rf_wd !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_wd: got %h expected 00001234", wb.rf_wd); end
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle_we: got %0b expected 0", wb.rf_we); end
    endtask

    task automatic test_collision();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd3;
        wb.alu_data  = 32'hAAAA_0003;
        wb.ld_valid  = 1'b1;
        wb.ld_rd     = 5'd7;
        wb.ld_data   = 32'hBBBB_0007;
        #1;
        checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_ready: got %0b expected 1", wb.ld_ready); end
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL coll_alu_we: got %0b expected 1", wb.rf_we); end
        checks++; if (wb.rf_wr !== 5'd3) begin errors++; $display("[TB] FAIL coll_alu_wr: got %0d expected 3", wb.rf_wr); end
        checks++; if (wb.rf_wd !== 32'hAAAA_0003) begin errors++; $display("[TB] FAIL coll_alu_wd: got %h expected aaaa0003", wb.rf_wd); end
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL coll_ld_we: got %0b expected 1", wb.rf_we); end
        checks++; if (wb.rf_wr !== 5'd7) begin errors++; $display("[TB] FAIL coll_ld_wr: got %0d expected 7", wb.rf_wr); end
        checks++; if (wb.rf_wd !== 32'hBBBB_0007) begin errors++; $display("[TB] FAIL coll_ld_wd: got %h expected bbbb0007", wb.rf_wd); end
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL coll_idle_we: got %0b expected 0", wb.rf_we); end
    endtask

    task automatic test_back_pressure();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd1;
        wb.alu_data  = 32'h0000_00A1;
        for (int i = 0; i < 4; i++) begin
            wb.ld_valid = 1'b1;
            wb.ld_rd    = 5'(10 + i);
            wb.ld_data  = 32'h5000 + 32'(i);
            #1;
            checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_%0d: got %0b expected 1", i, wb.ld_ready); end
            @(negedge clk);
        end
        wb.ld_rd   = 5'd14;
        wb.ld_data = 32'h5004;
        #1;
        checks++; if (wb.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %0b expected 0", wb.ld_ready); end
        checks++; if (wb.rf_wr !== 5'd1) begin errors++; $display("[TB] FAIL bp_alu_wr: got %0d expected 1", wb.rf_wr); end
        @(negedge clk);
        checks++; if (wb.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_ready: got %0b expected 0", wb.ld_ready); end
        checks++; if (wb.rf_we !== 1'b1 || wb.rf_wd !== 32'h0000_00A1) begin errors++; $display("[TB] FAIL bp_alu_write: got we=%0b wd=%h expected we=1 wd=000000a1", wb.rf_we, wb.rf_wd); end
        wb.alu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain_ready: got %0b expected 1", wb.ld_ready); end
            end
            if (i == 1) begin
                wb.ld_valid = 1'b0;
            end
            checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain_we_%0d: got %0b expected 1", i, wb.rf_we); end
            checks++; if (wb.rf_wr !== 5'(10 + i)) begin errors++; $display("[TB] FAIL bp_drain_wr_%0d: got %0d expected %0d", i, wb.rf_wr, 10 + i); end
            checks++; if (wb.rf_wd !== 32'h5000 + 32'(i)) begin errors++; $display("[TB] FAIL bp_drain_wd_%0d: got %h expected %h", i, wb.rf_wd, 32'h5000 + 32'(i)); end
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty_we: got %0b expected 0", wb.rf_we); end
    endtask

    task automatic test_x0();
        wb.alu_valid   = 1'b1;
        wb.alu_rd      = 5'd0;
        wb.alu_data    = 32'hDEAD_0000;
        wb.ld_valid    = 1'b1;
        wb.ld_rd       = 5'd0;
        wb.ld_data     = 32'hBEEF_0000;
        wb.issue_valid = 1'b1;
        wb.issue_rd    = 5'd0;
        #1;
        checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_ready: got %0b expected 1", wb.ld_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL x0_we_%0d: got %0b expected 0", i, wb.rf_we); end
            checks++; if (wb.busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL x0_busy_%0d: got %0b expected 0", i, wb.busy[0]); end
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL x0_after_we: got %0b expected 0", wb.rf_we); end
        // An empty queue means a fresh load lands exactly two cycles later.
        wb.ld_valid = 1'b1;
        wb.ld_rd    = 5'd8;
        wb.ld_data  = 32'h0000_0888;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL x0_probe_early: got %0b expected 0", wb.rf_we); end
        @(negedge clk);
        checks++; if (wb.rf_we !== 1'b1 || wb.rf_wr !== 5'd8 || wb.rf_wd !== 32'h0000_0888) begin errors++; $display("[TB] FAIL x0_probe_write: got we=%0b wr=%0d wd=%h expected we=1 wr=8 wd=00000888", wb.rf_we, wb.rf_wr, wb.rf_wd); end
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        wb.issue_valid = 1'b1;
        wb.issue_rd    = 5'd9;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.busy !== 32'h0000_0200) begin errors++; $display("[TB] FAIL sb_set: got %h expected 00000200", wb.busy); end
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd9;
        wb.alu_data  = 32'h0000_0099;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.rf_we !== 1'b1 || wb.rf_wr !== 5'd9) begin errors++; $display("[TB] FAIL sb_write: got we=%0b wr=%0d expected we=1 wr=9", wb.rf_we, wb.rf_wr); end
        wb.issue_valid = 1'b1;
        wb.issue_rd    = 5'd9;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL sb_set_wins: got %0b expected 1", wb.busy[9]); end
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd9;
        wb.alu_data  = 32'h0000_0999;
        @(negedge clk);
        clear_inputs();
        checks++; if (wb.busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL sb_pending: got %0b expected 1", wb.busy[9]); end
        @(negedge clk);
        checks++; if (wb.busy !== 32'h0) begin errors++; $display("[TB] FAIL sb_clear: got %h expected 00000000", wb.busy); end
    endtask

    task automatic test_reset_midop();
        wb.alu_valid   = 1'b1;
        wb.alu_rd      = 5'd2;
        wb.alu_data    = 32'h0000_0022;
        wb.issue_valid = 1'b1;
        wb.issue_rd    = 5'd6;
        for (int i = 0; i < 3; i++) begin
            wb.ld_valid = 1'b1;
            wb.ld_rd    = 5'(20 + i);
            wb.ld_data  = 32'h7000 + 32'(i);
            @(negedge clk);
        end
        checks++; if (wb.rf_we !== 1'b1 || wb.busy[6] !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: got we=%0b busy6=%0b expected we=1 busy6=1", wb.rf_we, wb.busy[6]); end
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_we: got %0b expected 0", wb.rf_we); end
        checks++; if (wb.busy !== 32'h0) begin errors++; $display("[TB] FAIL rst_async_busy: got %h expected 00000000", wb.busy); end
        checks++; if (wb.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_ready: got %0b expected 1", wb.ld_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_we_%0d: got %0b expected 0", i, wb.rf_we); end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu_write();
        test_collision();
        test_back_pressure();
        test_x0();
        test_scoreboard();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 4, meaning load-result queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port alu_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port ld_valid  input  1  load result offered.
REQ-008 SHALL have port ld_ready  output  1  load result accepted when ld_valid&&ld_ready.
REQ-009 SHALL have port ld_rd  input  5  load destination register.
REQ-010 SHALL have port ld_data  input  32  load result.
REQ-011 SHALL have port issue_valid  input  1  instruction with destination issued.
REQ-012 SHALL have port issue_rd  input  5  issued destination register.
REQ-013 SHALL have port rf_we  output  1  register-file write enable.
REQ-014 SHALL have port rf_wr  output  5  register-file write address.
REQ-015 SHALL have port rf_wd  output  32  register-file write data.
REQ-016 SHALL have port busy  output  32  per-register pending-write scoreboard.

Function
REQ-017 SHALL drive rf_we/rf_wr/rf_wd from registers; at most one RF write per cycle.
REQ-018 SHALL give ALU results absolute priority: alu_valid with alu_rd!=0 in cycle N -> rf_we=1, rf_wr=alu_rd, rf_wd=alu_data in cycle N+1.
REQ-019 SHALL enqueue accepted load results into a FIFO of LQ_DEPTH entries; ld_ready = !full (combinational from registered count).
REQ-020 SHALL drain the FIFO head to the RF (one-cycle latency, as REQ-018) only in cycles with no ALU write to a nonzero register.
REQ-021 SHALL drop writes to x0: ALU results with alu_rd=0 produce no rf_we; loads with ld_rd=0 are accepted but not enqueued.
REQ-022 SHALL support simultaneous enqueue and dequeue when full: ld_ready stays 0 while full (no same-cycle pass-through).
REQ-023 SHALL wrap read/write pointers modulo LQ_DEPTH; count range 0..LQ_DEPTH.
REQ-024 SHALL preserve load order: FIFO writes reach the RF in acceptance order.
REQ-025 SHALL set busy[issue_rd] on issue_valid with issue_rd!=0, effective next cycle.
REQ-026 SHALL clear busy[r] in the cycle after rf_we=1 with rf_wr=r.
REQ-027 SHALL give set priority over clear when both target the same register in one cycle.
REQ-028 SHALL hold busy[0]=0 permanently.
REQ-029 SHALL drive rf_we=0 whenever neither an ALU write nor a FIFO entry is pending.

Reset
REQ-030 SHALL on rst assertion asynchronously force rf_we=0, rf_wr=0, rf_wd=0, busy=0, FIFO count and pointers=0 (ld_ready=1).
REQ-031 SHALL discard queued loads and pending ALU writes on reset mid-operation; no rf_we in the first cycle after release.
REQ-032 SHALL not require FIFO data storage to be reset.

Structure
REQ-033 SHALL place the register-index width (5), data width (32) and register count (32) as constants in the shared CPU package.
REQ-034 SHALL implement the load queue as sub-module wb_fifo (parameterised depth/width, valid/ready push, pop strobe).
REQ-035 SHALL keep ALU-vs-queue arbitration and the scoreboard in rf_writeback itself.

Verification
REQ-036 SHALL test ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle rf_we=1, rf_wr=5, rf_wd=0x1234.
REQ-037 SHALL test collision: alu rd=3 and load rd=7 same cycle -> x3 written cycle N+1, x7 written cycle N+2.
REQ-038 SHALL test back-pressure: alu_valid held 1 (rd=1), push 5 loads with LQ_DEPTH=4 -> ld_ready=0 after 4th; release ALU -> loads drain in order, one per cycle.
REQ-039 SHALL test x0: alu_rd=0 and ld_rd=0 -> rf_we never asserted, FIFO count unchanged, busy[0]=0.
REQ-040 SHALL test scoreboard: issue rd=9 -> busy[9]=1; write x9 while re-issuing rd=9 same cycle -> busy[9] remains 1.
REQ-041 SHALL test reset with 3 queued loads -> rf_we=0, busy=0, ld_ready=1 immediately, no writes after release.
